// File: rtl/mdiv_pkg.sv
// rtl/mdiv_pkg.sv - shared constants and FSM state encoding for the mdiv host loader
package mdiv_pkg;

  localparam int MDIV_DW     = 32;
  localparam int MDIV_NWORDS = 8;
  localparam int MDIV_IDX_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_P,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_KICK,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } mdiv_state_e;

endpackage

// File: rtl/mdiv_word_mux.sv
// rtl/mdiv_word_mux.sv - selects one DW-bit word of a wide operand by word index
module mdiv_word_mux
  import mdiv_pkg::*;
#(
  parameter int DW     = MDIV_DW,
  parameter int NWORDS = MDIV_NWORDS
) (
  input  logic [DW*NWORDS-1:0] data_i,
  input  logic [MDIV_IDX_W-1:0] idx_i,
  output logic [DW-1:0]         word_o
);

  assign word_o = data_i[int'(idx_i)*DW +: DW];

endmodule

// File: rtl/mdiv_host_loader.sv
// rtl/mdiv_host_loader.sv - host driver for the 256-bit modular inverse/division engine
// Optional macro MDIV_LOADER_TIMEOUT_EN adds a WAIT/DRAIN cycle limit and the err output.
module mdiv_host_loader
  import mdiv_pkg::*;
#(
  parameter int DW     = MDIV_DW,
  parameter int NWORDS = MDIV_NWORDS
`ifdef MDIV_LOADER_TIMEOUT_EN
  , parameter int TMO_CYCLES = 65535
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_inv,
  input  logic [DW*NWORDS-1:0] a_in,
  input  logic [DW*NWORDS-1:0] b_in,
  input  logic [DW*NWORDS-1:0] p_in,
  output logic                 busy,
  output logic                 done,
  output logic [DW*NWORDS-1:0] result,
  output logic [DW-1:0]        datain,
  output logic                 loada,
  output logic                 loadb,
  output logic                 loadp,
  output logic                 minv_mdiv,
  output logic                 minv_mdiv_en,
  input  logic                 minv_mdiv_rdy,
  input  logic [DW-1:0]        result_out,
  input  logic                 out_valid,
`ifdef MDIV_LOADER_TIMEOUT_EN
  output logic                 err,
`endif
  output logic                 out_ready
);

  localparam int OPW = DW * NWORDS;
  localparam logic [MDIV_IDX_W-1:0] LAST_IDX = MDIV_IDX_W'(NWORDS - 1);

  mdiv_state_e           state_q;
  logic [MDIV_IDX_W-1:0] cnt_q;
  logic [OPW-1:0]        a_q, b_q, p_q, result_q;
  logic                  op_q;
  logic [OPW-1:0]        op_sel;

`ifdef MDIV_LOADER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);
  logic [15:0] tmo_q;
  logic        err_q;
  logic        tmo_hit;

  assign tmo_hit = (tmo_q == TMO_LAST);
  assign err     = err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      op_q     <= 1'b0;
      result_q <= '0;
`ifdef MDIV_LOADER_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= b_in;
            p_q     <= p_in;
            op_q    <= op_inv;
            cnt_q   <= '0;
            state_q <= ST_LOAD_P;
`ifdef MDIV_LOADER_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
          end
        end
        ST_LOAD_P: begin
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            state_q <= ST_LOAD_A;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LOAD_A: begin
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            state_q <= op_q ? ST_KICK : ST_LOAD_B;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LOAD_B: begin
          if (cnt_q == LAST_IDX) begin
            cnt_q   <= '0;
            state_q <= ST_KICK;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_KICK: state_q <= ST_WAIT;
        ST_WAIT: begin
`ifdef MDIV_LOADER_TIMEOUT_EN
          if (tmo_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else
`endif
          if (minv_mdiv_rdy) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // A word arriving on the expiry cycle is still kept.
          if (out_valid) begin
            result_q[int'(cnt_q)*DW +: DW] <= result_out;
            cnt_q <= (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_q <= ST_DONE;
          end
`ifdef MDIV_LOADER_TIMEOUT_EN
          if (tmo_hit) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_DONE;
          end
`endif
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
`ifdef MDIV_LOADER_TIMEOUT_EN
      if (state_q == ST_WAIT || state_q == ST_DRAIN) tmo_q <= tmo_q + 16'd1;
      else                                           tmo_q <= '0;
`endif
    end
  end

  always_comb begin
    op_sel = '0;
    case (state_q)
      ST_LOAD_P: op_sel = p_q;
      ST_LOAD_A: op_sel = a_q;
      ST_LOAD_B: op_sel = b_q;
      default:   op_sel = '0;
    endcase
  end

  mdiv_word_mux #(
    .DW     (DW),
    .NWORDS (NWORDS)
  ) u_word_mux (
    .data_i (op_sel),
    .idx_i  (cnt_q),
    .word_o (datain)
  );

  assign loadp        = (state_q == ST_LOAD_P);
  assign loada        = (state_q == ST_LOAD_A);
  assign loadb        = (state_q == ST_LOAD_B);
  assign minv_mdiv_en = (state_q == ST_KICK);
  assign out_ready    = (state_q == ST_DRAIN);
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign minv_mdiv    = busy & op_q;
  assign result       = result_q;

endmodule

// File: tb/tb_mdiv_host_loader.sv
// tb/tb_mdiv_host_loader.sv - table-driven and randomized bench with an engine model for mdiv_host_loader
module tb_mdiv_host_loader;

  localparam int NW  = 8;
  localparam int TMO = 100;

  typedef struct {
    bit           op;
    logic [255:0] a, b, p;
    int           dly;
    bit           gaps;
    bit           no_rdy;
    logic [255:0] exp_res;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0, op_inv = 1'b0;
  logic [255:0] a_in = '0, b_in = '0, p_in = '0;
  logic         busy, done, loada, loadb, loadp, minv_mdiv, minv_mdiv_en, out_ready;
  logic [255:0] result;
  logic [31:0]  datain;
  logic         minv_mdiv_rdy = 1'b0, out_valid = 1'b0;
  logic [31:0]  result_out = '0;
`ifdef MDIV_LOADER_TIMEOUT_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;
  logic [255:0] last_res = '0;

  always #5 clk = ~clk;

`ifdef MDIV_LOADER_TIMEOUT_EN
  mdiv_host_loader #(.TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .op_inv(op_inv),
    .a_in(a_in), .b_in(b_in), .p_in(p_in),
    .busy(busy), .done(done), .result(result), .datain(datain),
    .loada(loada), .loadb(loadb), .loadp(loadp),
    .minv_mdiv(minv_mdiv), .minv_mdiv_en(minv_mdiv_en), .minv_mdiv_rdy(minv_mdiv_rdy),
    .result_out(result_out), .out_valid(out_valid),
    .err(err),
    .out_ready(out_ready)
  );
`else
  mdiv_host_loader dut (
    .clk(clk), .rst(rst), .start(start), .op_inv(op_inv),
    .a_in(a_in), .b_in(b_in), .p_in(p_in),
    .busy(busy), .done(done), .result(result), .datain(datain),
    .loada(loada), .loadb(loadb), .loadp(loadp),
    .minv_mdiv(minv_mdiv), .minv_mdiv_en(minv_mdiv_en), .minv_mdiv_rdy(minv_mdiv_rdy),
    .result_out(result_out), .out_valid(out_valid),
    .out_ready(out_ready)
  );
`endif

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < NW; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int count_bad(logic [31:0] q[$], logic [255:0] v);
    int bad = 0;
    for (int i = 0; i < q.size() && i < NW; i++)
      if (q[i] !== v[i*32 +: 32]) bad++;
    return bad;
  endfunction

  task automatic check_idle_outputs(string tag);
    check({tag, "_loadp"}, loadp, 0);
    check({tag, "_loada"}, loada, 0);
    check({tag, "_loadb"}, loadb, 0);
    check({tag, "_datain"}, datain, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_en"}, minv_mdiv_en, 0);
    check({tag, "_mode"}, minv_mdiv, 0);
    check({tag, "_out_ready"}, out_ready, 0);
    check({tag, "_result"}, result, 0);
  endtask

  // One full operation: drive start, play the engine, observe every cycle at negedge.
  task automatic run_op(input vec_t v, input bit poke);
    logic [31:0]  pw[$], aw[$], bw[$];
    int           cyc, en_cyc, en_cnt, done_cyc, multi, busy_bad, widx, exp_done;
    bit           xfer, tog, mode_bad, done_busy;
    logic [255:0] res_at_done;
    en_cyc = -1; en_cnt = 0; done_cyc = -1; multi = 0; busy_bad = 0; widx = 0;
    xfer = 0; tog = 1; mode_bad = 0; done_busy = 0; res_at_done = '0;

    @(negedge clk);
    op_inv = v.op; a_in = v.a; b_in = v.op ? rnd256() : v.b; p_in = v.p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
`ifdef MDIV_LOADER_TIMEOUT_EN
    check("err_cleared_on_start", err, 0);
`endif
    while (done_cyc < 0 && cyc < 4000) begin
      start = poke && (cyc == 5);
      if (32'(loadp) + 32'(loada) + 32'(loadb) > 1) multi++;
      if (loadp) pw.push_back(datain);
      if (loada) aw.push_back(datain);
      if (loadb) bw.push_back(datain);
      if (!done && !busy) busy_bad++;
      if (minv_mdiv_en) begin
        en_cnt++;
        en_cyc = cyc;
        if (minv_mdiv !== v.op) mode_bad = 1;
      end
      if (done) begin
        done_cyc = cyc;
        done_busy = busy;
        res_at_done = result;
        if (poke) start = 1'b1;
      end
      if (xfer) widx++;
      minv_mdiv_rdy = (en_cyc >= 0 && !v.no_rdy && cyc >= en_cyc + v.dly && widx < NW);
      if (out_ready && widx < NW) begin
        out_valid  = v.gaps ? tog : 1'b1;
        tog        = ~tog;
        result_out = v.exp_res[widx*32 +: 32];
      end else begin
        out_valid  = 1'b0;
        result_out = $urandom;
      end
      xfer = out_valid && out_ready;
      @(negedge clk);
      cyc++;
    end
    minv_mdiv_rdy = 1'b0;
    out_valid = 1'b0;

    check("done_seen", done_cyc >= 0, 1);
    check("p_count", pw.size(), NW);
    check("p_words", count_bad(pw, v.p), 0);
    check("a_count", aw.size(), NW);
    check("a_words", count_bad(aw, v.a), 0);
    check("b_count", bw.size(), v.op ? 0 : NW);
    if (!v.op) check("b_words", count_bad(bw, v.b), 0);
    check("one_strobe", multi, 0);
    check("busy_held", busy_bad, 0);
    check("en_count", en_cnt, 1);
    check("en_cycle", en_cyc, 1 + (v.op ? 2 : 3) * NW);
    check("en_mode", mode_bad, 0);
    check("busy_at_done", done_busy, 0);
    check("result", res_at_done, v.exp_res);
    exp_done = v.no_rdy ? en_cyc + 1 + TMO : en_cyc + v.dly + (v.gaps ? 2 * NW : NW + 1);
    check("done_cycle", done_cyc, exp_done);
`ifdef MDIV_LOADER_TIMEOUT_EN
    check("err_at_done", err, v.no_rdy);
`endif
    check("done_pulse", done, 0);
    check("out_ready_dropped", out_ready, 0);
    start = 1'b0;
    @(negedge clk);
    check("start_in_done_ignored_busy", busy, 0);
    check("start_in_done_ignored_load", loadp, 0);
    check("result_held", result, v.exp_res);
    last_res = v.exp_res;
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    for (int i = 0; i < 10; i++) begin
      tbl[i].op = $urandom_range(0, 1);
      tbl[i].a = rnd256(); tbl[i].b = rnd256(); tbl[i].p = rnd256();
      tbl[i].dly = $urandom_range(1, 30);
      tbl[i].gaps = $urandom_range(0, 1);
      tbl[i].no_rdy = 0;
      tbl[i].exp_res = rnd256();
    end
    tbl[0].op = 0; tbl[0].p = ~256'd2; tbl[0].a = 256'd1; tbl[0].b = 256'd2;
    tbl[0].dly = 50; tbl[0].gaps = 0;
    for (int i = 0; i < NW; i++) tbl[0].exp_res[i*32 +: 32] = 32'(i);
    tbl[1].op = 1; tbl[1].dly = 50; tbl[1].gaps = 0; tbl[1].exp_res = tbl[0].exp_res;
    tbl[2].op = 0; tbl[2].gaps = 1; tbl[2].dly = 3;
    tbl[3].op = 1; tbl[3].gaps = 1; tbl[3].dly = 1;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    for (int i = 0; i < 10; i++) run_op(tbl[i], (i % 2) == 0);

    // Reset in the middle of LOAD_A, then a fresh division must reload everything.
    @(negedge clk);
    op_inv = 1'b0; a_in = rnd256(); b_in = rnd256(); p_in = rnd256(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !loada; k++) @(negedge clk);
    check("reached_load_a", loada, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    run_op(tbl[0], 1'b0);

`ifdef MDIV_LOADER_TIMEOUT_EN
    v = tbl[2];
    v.no_rdy = 1;
    v.exp_res = last_res;
    run_op(v, 1'b0);
    run_op(tbl[1], 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdiv_host_loader.md
Name: mdiv_host_loader

Overview:
Host-side driver for the 256-bit modular inverse/division engine. Latches 256-bit operands a, b and p on a start request and serialises them onto the engine's 32-bit load bus with loada/loadb/loadp strobes. It then pulses the engine enable, waits for the engine's ready flag, drains the 8-word result over the out_valid/out_ready handshake, and presents the reassembled 256-bit result to the host.

Parameters:
DW, 32, engine bus word width in bits
NWORDS, 8, words per 256-bit operand (DW*NWORDS = 256)

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
start  in  1  host request; sampled only in IDLE
op_inv  in  1  1 = modular inverse, 0 = modular division; latched at start
a_in  in  256  operand a (division: numerator side)
b_in  in  256  operand b; ignored when op_inv=1
p_in  in  256  modulus p
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when result is valid
result  out  256  assembled result; held until the next accepted start
datain  out  32  engine load word
loada  out  1  engine strobe: datain is a word of a
loadb  out  1  engine strobe: datain is a word of b
loadp  out  1  engine strobe: datain is a word of p
minv_mdiv  out  1  mode to engine; equals latched op_inv while busy
minv_mdiv_en  out  1  one-cycle start pulse to engine
minv_mdiv_rdy  in  1  engine completion flag (level)
result_out  in  32  engine result word
out_valid  in  1  engine result word valid
out_ready  out  1  loader accepts a result word

Behaviour:
- Reset: all outputs 0, result = 0, state IDLE, word counter 0. Reset mid-operation aborts immediately; the engine is not notified, and the next start reloads every operand.
- FSM states: IDLE, LOAD_P, LOAD_A, LOAD_B, KICK, WAIT, DRAIN, DONE.
- IDLE: when start=1, latch a_in, b_in, p_in and op_inv into shadow registers and go to LOAD_P. busy rises on the following cycle.
- LOAD_x: one word per cycle, least-significant word first (bits [31:0] first). The matching strobe is high for exactly NWORDS consecutive cycles, datain carries the current word, and the counter wraps from NWORDS-1 to 0 on the state change. Exactly one strobe is high in any cycle.
- Load order is P, then A, then B. When op_inv=1, LOAD_B is skipped (LOAD_A goes to KICK).
- KICK: minv_mdiv_en=1 for one cycle, then go to WAIT.
- WAIT: stay until minv_mdiv_rdy=1, then go to DRAIN. If rdy is already high on the cycle after KICK, enter DRAIN immediately.
- DRAIN: out_ready=1. Each cycle with out_valid && out_ready, place result_out into result word [counter], LSW first. After word NWORDS-1 is accepted, drop out_ready in the next cycle and go to DONE. out_valid gaps stall the loader without timeout, unless the optional feature is compiled in.
- DONE: done=1 for one cycle, busy=0, then return to IDLE.
- Total latency from an accepted start to done = 1 + 3*NWORDS (division) or 1 + 2*NWORDS (inverse) + 1 (KICK) + engine time + NWORDS + 1.
- start while busy is ignored. start in the DONE cycle is ignored. Back-to-back operations need start in IDLE.
- result is not modified outside DRAIN.

Optional Feature:
MDIV_LOADER_TIMEOUT_EN
- With the macro defined: add parameter TMO_CYCLES (default 65535), a 16-bit cycle counter that runs in WAIT and DRAIN, and output err (1 bit). On expiry, the FSM goes to DONE, done pulses with err=1, and result keeps the words received so far. err clears on the next accepted start.
- Without the macro: no counter and no err port, and WAIT/DRAIN wait indefinitely.

Decomposition:
- Package mdiv_pkg holds: the FSM state enum, the DW/NWORDS defaults, and the word-index width constant (3 bits).
- One sub-module, mdiv_word_mux: a 256-to-32 word selector indexed by the counter, used for datain. Result assembly stays inline in the top.

Test Plan:
- Division, p=0xFFFF_FFFF_..._FFFF_FFFD, a=0x1, b=0x2 -> loadp for 8 cycles with first datain=0xFFFFFFFD, then loada for 8 (first 0x00000001), then loadb for 8 (first 0x00000002), then one minv_mdiv_en pulse with minv_mdiv=0.
- Inverse, op_inv=1 -> no loadb cycles. minv_mdiv_en follows the 16th load cycle with minv_mdiv=1.
- Engine model asserts rdy 50 cycles after the enable, then streams words 0x0..0x7 with out_valid held high -> result = {0x7,...,0x1,0x0}, one done pulse, busy low.
- out_valid toggled 1,0,1,0 during DRAIN -> exactly 8 words captured, in order, with no duplicates.
- Reset asserted mid-LOAD_A -> all strobes and outputs 0 asynchronously. After release, a new start produces a full P/A/B sequence.
- With MDIV_LOADER_TIMEOUT_EN and TMO_CYCLES=100, rdy never asserted -> done with err=1 at 100 cycles into WAIT. The next start clears err.
